piso_shift_ctrl: RTL and testbench

Sequencer for the 4-bit shift-register datapath. It accepts a parallel word over a valid/ready handshake and loads it into an internal register. It then shifts the word out serially, MSB-first or LSB-first, one bit per clock. It signals completion and only then accepts the next word. It sits between a parallel producer (e.g. a PIPO stage) and a serial consumer.

---
 rtl/piso_shift_ctrl.sv | 98 +++++++++
 tb/tb_piso_shift_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_shift_ctrl.sv
// Parallel-in serial-out sequencer: accepts a word over valid/ready, shifts it out one bit per clock.
// Latency: first bit 1 cycle after accept, done pulse WIDTH+1 cycles after; in_ready held low while busy.
module piso_shift_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ins,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             msb_first,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] outs
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             dir_q;
    logic             sout_valid_q;
    logic             busy_q;
    logic             done_q;
    logic             accept;

    // Shift toward the output end so the next bit always sits at the same position.
    always_comb begin
        sreg_d = dir_q ? (sreg_q << 1) : (sreg_q >> 1);
        cnt_d  = cnt_q + CNT_W'(1);
    end

    assign in_ready   = (state_q == IDLE) && !rst;
    assign accept     = in_valid && in_ready;
    assign sout_valid = sout_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign outs       = sreg_q;
    assign sout       = sout_valid_q && (dir_q ? sreg_q[WIDTH-1] : sreg_q[0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sreg_q       <= '0;
            cnt_q        <= '0;
            dir_q        <= 1'b0;
            sout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        state_q      <= SHIFT;
                        sreg_q       <= ins;
                        dir_q        <= msb_first;
                        cnt_q        <= '0;
                        sout_valid_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                SHIFT: begin
                    sreg_q <= sreg_d;
                    cnt_q  <= cnt_d;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q      <= DONE;
                        sout_valid_q <= 1'b0;
                        done_q       <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q      <= IDLE;
                    sout_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_shift_ctrl.sv
// Randomised and directed bench for piso_shift_ctrl against a word-level serialisation model.
module tb_piso_shift_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] ins;
    logic         in_valid;
    logic         in_ready;
    logic         msb_first;
    logic         sout;
    logic         sout_valid;
    logic         busy;
    logic         done;
    logic [W-1:0] outs;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int acc_q[$];
    logic bits_q[$];

    piso_shift_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .ins        (ins),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .msb_first  (msb_first),
        .sout       (sout),
        .sout_valid (sout_valid),
        .busy       (busy),
        .done       (done),
        .outs       (outs)
    );

    always #5 clk = ~clk;

    // Observe handshakes and the serial stream at the edge, before state updates.
    always @(posedge clk) begin
        if (in_valid === 1'b1 && in_ready === 1'b1 && rst === 1'b0) acc_q.push_back(cyc);
        if (sout_valid === 1'b1) bits_q.push_back(sout);
        cyc = cyc + 1;
    end

    // Reference model: k-th bit and register image after k shifts of word w.
    function automatic logic exp_bit(logic [W-1:0] w, logic m, int k);
        return m ? w[W-1-k] : w[k];
    endfunction

    function automatic logic [W-1:0] exp_outs(logic [W-1:0] w, logic m, int k);
        logic [W-1:0] r;
        r = m ? (w << k) : (w >> k);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [W-1:0] w, input logic m);
        int n;
        in_valid  = 1'b1;
        ins       = w;
        msb_first = m;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL load_wait: in_ready=%b required 1 within 20 cycles", in_ready);
        end
        step();
        in_valid = 1'b0;
        ins      = W'($urandom);
    endtask

    task automatic test_word(input logic [W-1:0] w, input logic m, input logic flip);
        load_word(w, m);
        if (flip) msb_first = ~m;
        for (int k = 0; k < W; k++) begin
            tests += 4;
            if (sout_valid !== 1'b1) begin
                fails++;
                $display("FAIL word_sout_valid w=%b k=%0d: got %b required 1", w, k, sout_valid);
            end
            if (sout !== exp_bit(w, m, k)) begin
                fails++;
                $display("FAIL word_sout w=%b m=%b k=%0d: got %b required %b", w, m, k, sout, exp_bit(w, m, k));
            end
            if (outs !== exp_outs(w, m, k)) begin
                fails++;
                $display("FAIL word_outs w=%b m=%b k=%0d: got %b required %b", w, m, k, outs, exp_outs(w, m, k));
            end
            if (busy !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin
                fails++;
                $display("FAIL word_flags k=%0d: busy=%b in_ready=%b done=%b required 1 0 0", k, busy, in_ready, done);
            end
            if (k == 1) ins = W'($urandom);
            step();
        end
        tests += 2;
        if (done !== 1'b1 || busy !== 1'b1 || sout_valid !== 1'b0 || sout !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL done_cycle: done=%b busy=%b sv=%b sout=%b rdy=%b required 1 1 0 0 0",
                     done, busy, sout_valid, sout, in_ready);
        end
        if (outs !== '0) begin
            fails++;
            $display("FAIL done_outs: got %b required 0000", outs);
        end
        step();
        tests++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL back_to_idle: rdy=%b busy=%b done=%b required 1 0 0", in_ready, busy, done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; ins = 4'b1111; msb_first = 1'b1;
        step();
        step();
        tests += 2;
        if (in_ready !== 1'b0 || busy !== 1'b0 || sout_valid !== 1'b0 || done !== 1'b0 || sout !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: rdy=%b busy=%b sv=%b done=%b sout=%b required all 0",
                     in_ready, busy, sout_valid, done, sout);
        end
        if (outs !== '0) begin
            fails++;
            $display("FAIL reset_outs: got %b required 0000", outs);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        tests += 2;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: got %b required 1", in_ready);
        end
        if (acc_q.size() != 0) begin
            fails++;
            $display("FAIL reset_no_accept: got %0d accepts required 0", acc_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [7:0] stream;
        acc_q.delete();
        bits_q.delete();
        in_valid = 1'b1; ins = 4'b0111; msb_first = 1'b1;
        n = 0;
        while (acc_q.size() < 1 && n < 20) begin step(); n++; end
        ins = 4'b0001;
        n = 0;
        while (acc_q.size() < 2 && n < 20) begin
            tests++;
            if (busy === 1'b1 && in_ready !== 1'b0) begin
                fails++;
                $display("FAIL b2b_ready_while_busy: in_ready=%b required 0", in_ready);
            end
            step();
            n++;
        end
        in_valid = 1'b0;
        repeat (W + 2) step();
        tests += 2;
        if (acc_q.size() != 2 || (acc_q[1] - acc_q[0]) != W + 2) begin
            fails++;
            $display("FAIL b2b_spacing: accepts=%0d gap=%0d required 2 and %0d",
                     acc_q.size(), (acc_q.size() == 2) ? acc_q[1] - acc_q[0] : -1, W + 2);
        end
        if (bits_q.size() != 2 * W) begin
            fails++;
            $display("FAIL b2b_bitcount: got %0d required %0d", bits_q.size(), 2 * W);
        end else begin
            stream = 8'b0111_0001;
            for (int i = 0; i < 2 * W; i++) begin
                tests++;
                if (bits_q[i] !== stream[2*W-1-i]) begin
                    fails++;
                    $display("FAIL b2b_bit%0d: got %b required %b", i, bits_q[i], stream[2*W-1-i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        load_word(4'b1010, 1'b1);
        tests++;
        if (sout !== 1'b1) begin
            fails++;
            $display("FAIL midrst_bit0: got %b required 1", sout);
        end
        step();
        tests++;
        if (sout !== 1'b0) begin
            fails++;
            $display("FAIL midrst_bit1: got %b required 0", sout);
        end
        rst = 1'b1;
        step();
        tests++;
        if (sout_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || outs !== '0) begin
            fails++;
            $display("FAIL midrst_abort: sv=%b busy=%b done=%b outs=%b required 0 0 0 0000",
                     sout_valid, busy, done, outs);
        end
        rst = 1'b0;
        for (int i = 0; i < W + 2; i++) begin
            tests++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL midrst_no_done c%0d: done=%b busy=%b required 0 0", i, done, busy);
            end
            step();
        end
        test_word(4'b0001, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [W-1:0] w;
        logic m;
        logic f;
        for (int i = 0; i < 25; i++) begin
            w = W'($urandom);
            m = 1'($urandom);
            f = 1'($urandom);
            repeat ($urandom_range(0, 3)) step();
            test_word(w, m, f);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; ins = '0; msb_first = 1'b0;
        test_reset();
        test_word(4'b1010, 1'b1, 1'b0);
        test_word(4'b1100, 1'b0, 1'b0);
        test_back_to_back();
        test_reset_mid_shift();
        test_word(4'b1100, 1'b1, 1'b1);
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
